// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl: time-multiplexed seven-segment scan controller with frame-synchronous display word update.
// Optional build macro LED_SCAN_ZERO_BLANK_EN enables leading-zero suppression on the digit selects.
module led_scan_ctrl #(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load_req,
    input  logic [4*DIGITS-1:0]   data,
    output logic                  load_ack,
    output logic [3:0]            num,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_start
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int TW = $clog2(SCAN_DIV);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DIGITS - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(SCAN_DIV - 1);

    logic [TW-1:0]       r_tick;
    logic [IW-1:0]       r_idx;
    logic                r_run;
    logic [4*DIGITS-1:0] r_disp;
    logic [4*DIGITS-1:0] r_pend;
    logic                r_pend_vld;

    logic                w_tick_wrap;
    logic                w_frame;
    logic                w_apply;
    logic [TW-1:0]       w_next_tick;
    logic [IW-1:0]       w_next_idx;
    logic [4*DIGITS-1:0] w_next_disp;
    logic [DIGITS-1:0]   w_lit;

    // r_run is low on the first enabled edge so digit 0 gets a full slot after (re)enable
    assign w_tick_wrap = en && r_run && (r_tick == LAST_TICK);
    assign w_frame     = w_tick_wrap && (r_idx == LAST_IDX);
    assign w_apply     = r_pend_vld && (w_frame || !en);
    assign w_next_tick = (en && r_run && !w_tick_wrap) ? r_tick + 1'b1 : '0;
    assign w_next_idx  = !en ? '0 : w_frame ? '0 : w_tick_wrap ? r_idx + 1'b1 : r_idx;
    assign w_next_disp = w_apply ? r_pend : r_disp;

`ifdef LED_SCAN_ZERO_BLANK_EN
    // A digit is lit if it or any more significant nibble is nonzero; digit 0 always lit
    always_comb begin
        logic w_seen;
        w_lit  = '0;
        w_seen = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_seen   = w_seen | (w_next_disp[4*i +: 4] != 4'd0) | (i == 0);
            w_lit[i] = w_seen;
        end
    end
`else
    assign w_lit = '1;
`endif

    // Slot timer and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick <= '0;
            r_idx  <= '0;
            r_run  <= 1'b0;
        end else begin
            r_tick <= w_next_tick;
            r_idx  <= w_next_idx;
            r_run  <= en;
        end
    end

    // Pending capture and frame-synchronous transfer to the visible word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp     <= '0;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
        end else begin
            r_disp <= w_next_disp;
            if (load_req) begin
                r_pend     <= data;
                r_pend_vld <= 1'b1;
            end else if (w_apply) begin
                r_pend_vld <= 1'b0;
            end
        end
    end

    // Registered pin outputs track the next index and next visible word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an          <= '0;
            num         <= '0;
            load_ack    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            an          <= en ? ((DIGITS'(1) << w_next_idx) & w_lit) : '0;
            num         <= en ? w_next_disp[{w_next_idx, 2'b00} +: 4] : 4'd0;
            load_ack    <= w_apply;
            frame_start <= w_frame;
        end
    end
endmodule

// File: tb/tb_led_scan_ctrl.sv
// tb_led_scan_ctrl: scoreboard bench for led_scan_ctrl with DIGITS=4, SCAN_DIV=4.
module tb_led_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        load_req = 1'b0;
    logic [15:0] data = '0;
    logic        load_ack;
    logic [3:0]  num;
    logic [3:0]  an;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        en;
        logic        ld;
        logic [15:0] d;
        logic [3:0]  an;
        logic [3:0]  num;
        logic        ack;
        logic        fs;
    } ent_t;

    ent_t q[$];

    led_scan_ctrl #(.DIGITS(4), .SCAN_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load_req(load_req), .data(data),
        .load_ack(load_ack), .num(num), .an(an), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Stimulus for one cycle plus the outputs expected after that cycle's rising edge
    task automatic push(input logic e, input logic ld, input logic [15:0] d,
                        input logic [3:0] a, input logic [3:0] n, input logic ack, input logic fs);
        ent_t t;
        t.en = e; t.ld = ld; t.d = d; t.an = a; t.num = n; t.ack = ack; t.fs = fs;
        q.push_back(t);
    endtask

    function automatic logic [3:0] nib(input logic [15:0] w, input int dg);
        logic [15:0] v;
        v = w >> (4 * dg);
        return v[3:0];
    endfunction

    function automatic logic [3:0] exp_an(input logic [15:0] w, input int dg);
        logic lit;
        lit = 1'b1;
`ifdef LED_SCAN_ZERO_BLANK_EN
        lit = (dg == 0);
        for (int j = dg; j < 4; j++) if (nib(w, j) != 4'd0) lit = 1'b1;
`endif
        return lit ? 4'(1 << dg) : 4'b0000;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; en = 1'b0; load_req = 1'b0; data = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        ent_t t;
        int k;
        @(negedge clk);
        rst_n = 1'b0; en = 1'b1; load_req = 1'b1; data = 16'hFFFF;
        repeat (3) @(negedge clk);
        checks++;
        if ({an, num, load_ack, frame_start} !== 10'b0) begin
            errors++;
            $display("FAIL reset_hold outputs got %b expected 0", {an, num, load_ack, frame_start});
        end
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) push(1'b0, 1'b0, 16'h0, 4'b0, 4'h0, 1'b0, 1'b0);
        k = 0;
        while (q.size() > 0) begin
            t = q.pop_front();
            en = t.en; load_req = t.ld; data = t.d;
            @(negedge clk);
            checks++;
            if ({an, num, load_ack, frame_start} !== {t.an, t.num, t.ack, t.fs}) begin
                errors++;
                $display("FAIL reset_idle c%0d an/num/ack/fs got %b/%h/%b/%b expected %b/%h/%b/%b",
                         k, an, num, load_ack, frame_start, t.an, t.num, t.ack, t.fs);
            end
            k++;
        end
    endtask

    task automatic test_scan();
        ent_t t;
        int k;
        do_reset();
        for (int c = 0; c < 36; c++)
            push(1'b1, 1'b0, 16'h0, exp_an(16'h0, (c / 4) % 4), 4'h0, 1'b0, c > 0 && c % 16 == 0);
        k = 0;
        while (q.size() > 0) begin
            t = q.pop_front();
            en = t.en; load_req = t.ld; data = t.d;
            @(negedge clk);
            checks++;
            if ({an, num, load_ack, frame_start} !== {t.an, t.num, t.ack, t.fs}) begin
                errors++;
                $display("FAIL scan c%0d an/num/ack/fs got %b/%h/%b/%b expected %b/%h/%b/%b",
                         k, an, num, load_ack, frame_start, t.an, t.num, t.ack, t.fs);
            end
            k++;
        end
    endtask

    // Loads at cycles ca/cb; x1 becomes visible at the first wrap (c=16), x2 at the second (c=32)
    task automatic test_load(input string name, input int ca, input logic [15:0] da,
                             input int cb, input logic [15:0] db,
                             input logic x1v, input logic [15:0] x1,
                             input logic x2v, input logic [15:0] x2);
        ent_t t;
        int k;
        logic [15:0] w;
        int dg;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            w  = (c >= 32 && x2v) ? x2 : (c >= 16 && x1v) ? x1 : (c >= 32) ? x1 : 16'h0;
            if (c >= 16 && !x1v && !x2v) w = 16'h0;
            dg = (c / 4) % 4;
            push(1'b1, c == ca || c == cb, (c == ca) ? da : (c == cb) ? db : 16'h0,
                 exp_an(w, dg), nib(w, dg), (c == 16 && x1v) || (c == 32 && x2v), c > 0 && c % 16 == 0);
        end
        k = 0;
        while (q.size() > 0) begin
            t = q.pop_front();
            en = t.en; load_req = t.ld; data = t.d;
            @(negedge clk);
            checks++;
            if ({an, num, load_ack, frame_start} !== {t.an, t.num, t.ack, t.fs}) begin
                errors++;
                $display("FAIL %s c%0d an/num/ack/fs got %b/%h/%b/%b expected %b/%h/%b/%b",
                         name, k, an, num, load_ack, frame_start, t.an, t.num, t.ack, t.fs);
            end
            k++;
        end
    endtask

    task automatic test_enable_off();
        ent_t t;
        int k;
        logic e;
        logic [15:0] w;
        int dg;
        do_reset();
        for (int c = 0; c < 23; c++) begin
            e  = !(c == 9 || c == 10);
            w  = (c >= 9) ? 16'h5555 : 16'h0;
            dg = (c < 9) ? (c / 4) % 4 : (c >= 11) ? ((c - 11) / 4) % 4 : 0;
            push(e, c == 5, 16'h5555, e ? exp_an(w, dg) : 4'b0, e ? nib(w, dg) : 4'h0, c == 9, 1'b0);
        end
        push(1'b1, 1'b0, 16'h0, exp_an(16'h5555, 3), 4'h5, 1'b0, 1'b0);
        push(1'b1, 1'b1, 16'h7777, exp_an(16'h5555, 3), 4'h5, 1'b0, 1'b0);
        k = 0;
        while (q.size() > 0) begin
            t = q.pop_front();
            en = t.en; load_req = t.ld; data = t.d;
            @(negedge clk);
            checks++;
            if ({an, num, load_ack, frame_start} !== {t.an, t.num, t.ack, t.fs}) begin
                errors++;
                $display("FAIL en_off c%0d an/num/ack/fs got %b/%h/%b/%b expected %b/%h/%b/%b",
                         k, an, num, load_ack, frame_start, t.an, t.num, t.ack, t.fs);
            end
            k++;
        end
        load_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({an, num, load_ack, frame_start} !== 10'b0) begin
            errors++;
            $display("FAIL async_reset outputs got %b expected 0", {an, num, load_ack, frame_start});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++)
            push(1'b1, 1'b0, 16'h0, exp_an(16'h0, (c / 4) % 4), 4'h0, 1'b0, c > 0 && c % 16 == 0);
        k = 0;
        while (q.size() > 0) begin
            t = q.pop_front();
            en = t.en; load_req = t.ld; data = t.d;
            @(negedge clk);
            checks++;
            if ({an, num, load_ack, frame_start} !== {t.an, t.num, t.ack, t.fs}) begin
                errors++;
                $display("FAIL post_reset c%0d an/num/ack/fs got %b/%h/%b/%b expected %b/%h/%b/%b",
                         k, an, num, load_ack, frame_start, t.an, t.num, t.ack, t.fs);
            end
            k++;
        end
    endtask

    task automatic test_zero_blank(input logic [15:0] w);
        ent_t t;
        int k;
        do_reset();
        push(1'b0, 1'b1, w, 4'b0, 4'h0, 1'b0, 1'b0);
        push(1'b0, 1'b0, 16'h0, 4'b0, 4'h0, 1'b1, 1'b0);
        for (int c = 0; c < 20; c++)
            push(1'b1, 1'b0, 16'h0, exp_an(w, (c / 4) % 4), nib(w, (c / 4) % 4), 1'b0, c > 0 && c % 16 == 0);
        k = 0;
        while (q.size() > 0) begin
            t = q.pop_front();
            en = t.en; load_req = t.ld; data = t.d;
            @(negedge clk);
            checks++;
            if ({an, num, load_ack, frame_start} !== {t.an, t.num, t.ack, t.fs}) begin
                errors++;
                $display("FAIL zero_blank_%h c%0d an/num/ack/fs got %b/%h/%b/%b expected %b/%h/%b/%b",
                         w, k, an, num, load_ack, frame_start, t.an, t.num, t.ack, t.fs);
            end
            k++;
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load("load_mid", 5, 16'h1A2F, -1, 16'h0, 1'b1, 16'h1A2F, 1'b0, 16'h0);
        test_load("load_twice", 3, 16'h1111, 9, 16'h2222, 1'b1, 16'h2222, 1'b0, 16'h0);
        test_load("load_on_wrap", 5, 16'h3333, 16, 16'h4444, 1'b1, 16'h3333, 1'b1, 16'h4444);
        test_load("load_wrap_empty", 16, 16'h6666, -1, 16'h0, 1'b0, 16'h0, 1'b1, 16'h6666);
        test_enable_off();
        test_zero_blank(16'h00A0);
        test_zero_blank(16'h0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
